// File: rtl/mpadder_modred_pkg.sv
// Shared constants for the modular-reduction stage of the multi-precision adder.
// State encodings are plain localparams so older code can compare against them directly.
package mpmod_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_LIMB  = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_SEL  = 2'd2;

  // Counter must be at least one bit wide even for a single-limb build.
  function automatic int cntWidth(input int nLimbs);
    return (nLimbs <= 1) ? 1 : $clog2(nLimbs);
  endfunction

  localparam int DEF_CNT_W = cntWidth(DEF_WIDTH / DEF_LIMB);

endpackage

// File: rtl/mpadder_modred_limb_sub.sv
// One limb of the serial subtractor: {bout, d} = a - b - bin, purely combinational.
module mp_limb_sub #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            bin,
  output logic [LIMB-1:0] d,
  output logic            bout
);

  logic [LIMB:0] wide;

  assign wide = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
  assign d    = wide[LIMB-1:0];
  assign bout = wide[LIMB];

endmodule

// File: rtl/mpadder_modred.sv
// Reduces the adder's WIDTH+1-bit sum modulo M by one serial, limb-wise conditional subtraction.
// Optional feature: define MPADDER_MODRED_BYPASS_EN to add a bypass input that skips the reduction.
module mpadder_modred
  import mpmod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LIMB  = DEF_LIMB
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
`ifdef MPADDER_MODRED_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic [WIDTH:0]   S,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy
);

  localparam int NLIMBS = WIDTH / LIMB;
  localparam int CNT_W  = cntWidth(NLIMBS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NLIMBS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] regS;
  logic [WIDTH-1:0] regM;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sOrig;
  logic             sCarry;
  logic             bypassReg;
  logic [LIMB-1:0]  limbDiff;
  logic             limbBout;
  logic             useDiff;

  mp_limb_sub #(.LIMB(LIMB)) uLimbSub (
    .a    (regS[LIMB-1:0]),
    .b    (regM[LIMB-1:0]),
    .bin  (borrow),
    .d    (limbDiff),
    .bout (limbBout)
  );

  // A carry out of the adder means S >= 2^WIDTH > M, so the difference is always the answer.
`ifdef MPADDER_MODRED_BYPASS_EN
  assign useDiff = (sCarry | ~borrow) & ~bypassReg;
`else
  assign useDiff = sCarry | ~borrow;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      borrow    <= 1'b0;
      regS      <= '0;
      regM      <= '0;
      diff      <= '0;
      sOrig     <= '0;
      sCarry    <= 1'b0;
      bypassReg <= 1'b0;
      R         <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            regS   <= S[WIDTH-1:0];
            regM   <= M;
            sOrig  <= S[WIDTH-1:0];
            sCarry <= S[WIDTH];
            cnt    <= '0;
            borrow <= 1'b0;
`ifdef MPADDER_MODRED_BYPASS_EN
            bypassReg <= bypass;
`else
            bypassReg <= 1'b0;
`endif
            state  <= ST_SUB;
          end
        end
        ST_SUB: begin
          // Limbs enter from the top so the final limb lands in place after NLIMBS shifts.
          diff   <= {limbDiff, diff[WIDTH-1:LIMB]};
          regS   <= {{LIMB{1'b0}}, regS[WIDTH-1:LIMB]};
          regM   <= {{LIMB{1'b0}}, regM[WIDTH-1:LIMB]};
          borrow <= limbBout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= ST_SEL;
          end
        end
        ST_SEL: begin
          R     <= useDiff ? diff : sOrig;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_modred.sv
// Scoreboard bench for mpadder_modred: stimulus pushes expected results, a negedge monitor checks them.
// Define MPADDER_MODRED_BYPASS_EN to also exercise the bypass input.
module tb_mpadder_modred;

  localparam int W = 128;

  typedef struct {
    logic [W-1:0] r;
    int           cyc;
  } expEntry;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [W:0]   S;
  logic [W-1:0] M;
  logic [W-1:0] R;
  logic         done;
  logic         busy;
  logic         bypass;

  int      totalCount;
  int      badCount;
  int      cycle;
  expEntry expQ[$];

  mpadder_modred #(.WIDTH(128), .LIMB(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
`ifdef MPADDER_MODRED_BYPASS_EN
    .bypass (bypass),
`endif
    .S      (S),
    .M      (M),
    .R      (R),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: one conditional subtraction of M from the full WIDTH+1-bit sum, truncated.
  function automatic logic [W-1:0] modelR(input logic [W:0] s, input logic [W-1:0] m,
                                          input logic byp);
    logic [W:0] wide;
    logic [W:0] mWide;
    mWide = {1'b0, m};
    if (byp || (s < mWide)) wide = s;
    else wide = s - mWide;
    return wide[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: every done pulse must match the oldest expectation, both value and cycle.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", {127'd0, done}, '0);
      end else begin
        expEntry e;
        e = expQ.pop_front();
        checkOutput("resultR", R, e.r);
        checkOutput("doneCycle", W'(cycle), W'(e.cyc));
      end
    end
  end

  // Issue one request at a negedge while the DUT is idle, then spend its three busy cycles
  // driving junk inputs; junkStart 0 = low, 1 = held high, 2 = random pulses.
  task automatic applyStimulus(input logic [W:0] s, input logic [W-1:0] m, input logic byp,
                               input int junkStart);
    expEntry e;
    @(negedge clk);
    checkOutput("idleAtIssue", {127'd0, busy}, '0);
    start  = 1'b1;
    S      = s;
    M      = m;
    bypass = byp;
`ifdef MPADDER_MODRED_BYPASS_EN
    e.r = modelR(s, m, byp);
`else
    e.r = modelR(s, m, 1'b0);
`endif
    e.cyc = cycle + 4;
    expQ.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("busyHigh", {127'd0, busy}, {127'd0, 1'b1});
      start  = (junkStart == 1) ? 1'b1 : (junkStart == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      S      = {1'($urandom_range(0, 1)), rand128()};
      M      = rand128();
      bypass = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [W:0]   s;
    logic [W-1:0] m;
    logic [W:0]   twoM;
    logic [W-1:0] bigM;
    totalCount = 0;
    badCount   = 0;
    cycle      = 0;
    resetn     = 1'b0;
    start      = 1'b0;
    S          = '0;
    M          = '0;
    bypass     = 1'b0;
    #3;
    checkOutput("resetR", R, '0);
    checkOutput("resetDone", {127'd0, done}, '0);
    checkOutput("resetBusy", {127'd0, busy}, '0);
    @(negedge clk);
    resetn = 1'b1;

    bigM = {1'b0, {127{1'b1}}};
    applyStimulus(129'd3, 128'd7, 1'b0, 0);
    applyStimulus({1'b0, bigM} + 129'd5, bigM, 1'b0, 0);
    applyStimulus({1'b0, bigM}, bigM, 1'b0, 0);
    applyStimulus(129'd1 << 64, 128'd1, 1'b0, 0);
    applyStimulus((129'd1 << 128) + 129'd2, {128{1'b1}}, 1'b0, 0);
    applyStimulus(129'd5, 128'd5, 1'b0, 0);
`ifdef MPADDER_MODRED_BYPASS_EN
    applyStimulus({1'b0, bigM} + 129'd5, bigM, 1'b1, 0);
`endif

    // Start held high: back-to-back accepts, one every four cycles.
    for (int k = 0; k < 5; k++) begin
      m = rand128();
      s = {1'b0, rand128()};
      applyStimulus(s, m, 1'b0, 1);
    end

    // Random operands with random start pulses while busy, some beyond the 2M precondition.
    for (int k = 0; k < 30; k++) begin
      m    = rand128();
      if (k % 7 == 0) m = W'($urandom_range(1, 1000));
      twoM = {m, 1'b0};
      s    = {1'($urandom_range(0, 1)), rand128()};
      if ((k % 5 != 0) && (twoM != 0)) s = s % twoM;
      applyStimulus(s, m, 1'(($urandom_range(0, 3) == 0) ? 1 : 0), 2);
      start = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end

    // Abandon an operation mid-subtraction; nothing may come out of it.
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    S     = 129'd9;
    M     = 128'd4;
    @(negedge clk);
    start = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checkOutput("midResetR", R, '0);
    checkOutput("midResetDone", {127'd0, done}, '0);
    checkOutput("midResetBusy", {127'd0, busy}, '0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    applyStimulus(129'd20, 128'd7, 1'b0, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("pendingResults", W'(expQ.size()), '0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
